// File: rtl/stack_cpu_sequencer.sv
// Host-side sequencer for the nibble-serial stack core: replays accepted instructions
// onto the core's reset line and 4-bit input bus, inserting NOOP filler when idle.
module stack_cpu_sequencer #(
    parameter int RST_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_arg,
    output logic       cpu_rst,
    output logic [3:0] cpu_inbits,
    output logic       busy,
    output logic       retire
);

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [3:0] RST_CNT  = 4'(RST_CYCLES - 1);

    logic [1:0] state, state_d;
    logic [3:0] cnt, cnt_d;
    logic [3:0] op_q, op_d;
    logic [3:0] arg_q, arg_d;
    logic       user_q, user_d;
    logic       load_point;
    logic       accept;

    // Number of EXEC cycles the core spends on each opcode; unknown ops behave as NOOP.
    function automatic logic [3:0] exec_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8: exec_len = 4'd2;
            4'h9:                               exec_len = 4'd3;
            default:                            exec_len = 4'd1;
        endcase
    endfunction

    assign load_point = ((state == ST_RESET) || (state == ST_EXEC)) && (cnt == 4'd0);
    assign cmd_ready  = load_point && !rst;
    assign accept     = cmd_ready && cmd_valid;
    assign busy       = user_q && ((state == ST_FETCH) || (state == ST_EXEC));

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        op_d    = op_q;
        arg_d   = arg_q;
        user_d  = user_q;
        case (state)
            ST_RESET: begin
                if (cnt == 4'd0) state_d = ST_FETCH;
                else             cnt_d   = cnt - 4'd1;
            end
            ST_FETCH: begin
                state_d = ST_EXEC;
                cnt_d   = exec_len(op_q) - 4'd1;
            end
            ST_EXEC: begin
                if (cnt == 4'd0) state_d = ST_FETCH;
                else             cnt_d   = cnt - 4'd1;
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = RST_CNT;
            end
        endcase
        // Without a pending command the load point queues a NOOP so the core never idles on garbage.
        if (load_point) begin
            op_d   = accept ? cmd_op  : 4'h0;
            arg_d  = accept ? cmd_arg : 4'h0;
            user_d = accept;
        end
    end

    // Core-facing outputs are registered from next-state values so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RESET;
            cnt        <= RST_CNT;
            op_q       <= 4'h0;
            arg_q      <= 4'h0;
            user_q     <= 1'b0;
            cpu_rst    <= 1'b1;
            cpu_inbits <= 4'h0;
            retire     <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            user_q  <= user_d;
            cpu_rst <= (state_d == ST_RESET);
            case (state_d)
                ST_FETCH: cpu_inbits <= op_d;
                ST_EXEC:  cpu_inbits <= arg_d;
                default:  cpu_inbits <= 4'h0;
            endcase
            retire <= (state == ST_EXEC) && (cnt == 4'd0) && user_q;
        end
    end

endmodule

// File: tb/tb_stack_cpu_sequencer.sv
// Directed bench for stack_cpu_sequencer: each stimulus cycle pushes its hand-computed
// expected outputs into a scoreboard queue that a negedge monitor pops and compares.
module tb_stack_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = 4'h0;
    logic [3:0] cmd_arg = 4'h0;
    logic       cpu_rst;
    logic [3:0] cpu_inbits;
    logic       busy;
    logic       retire;

    typedef struct packed {
        logic       r;
        logic [3:0] bits;
        logic       rdy;
        logic       bsy;
        logic       ret;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_pass = 0;

    stack_cpu_sequencer #(.RST_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .cpu_rst    (cpu_rst),
        .cpu_inbits (cpu_inbits),
        .busy       (busy),
        .retire     (retire)
    );

    always #5 clk = ~clk;

    // Monitor: every expected record pushed during a cycle is checked at that cycle's negedge.
    always @(negedge clk) begin
        exp_t  e;
        exp_t  a;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = '{r: cpu_rst, bits: cpu_inbits, rdy: cmd_ready, bsy: busy, ret: retire};
            n_checks++;
            if (a === e) n_pass++;
            else $display("[TB] FAIL %s: got rst/bits/rdy/busy/ret=%b/%h/%b/%b/%b want %b/%h/%b/%b/%b",
                          t, a.r, a.bits, a.rdy, a.bsy, a.ret, e.r, e.bits, e.rdy, e.bsy, e.ret);
        end
    end

    task automatic applyStimulus(input string tag, input logic r, input logic v,
                                 input logic [3:0] op, input logic [3:0] arg, input logic chk,
                                 input logic er, input logic [3:0] eb, input logic erdy,
                                 input logic ebsy, input logic eret);
        @(posedge clk);
        #1;
        rst       = r;
        cmd_valid = v;
        cmd_op    = op;
        cmd_arg   = arg;
        if (chk) begin
            exp_q.push_back('{r: er, bits: eb, rdy: erdy, bsy: ebsy, ret: eret});
            tag_q.push_back(tag);
        end
    endtask

    task automatic doReset(input string tag);
        applyStimulus({tag, "_rstA"}, 1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0);
        applyStimulus({tag, "_rstB"}, 1, 0, 4'h0, 4'h0, 1, 1, 4'h0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no finish want finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset and idle filler.
        doReset("t1");
        applyStimulus("t1_r1", 0, 0, 4'h0, 4'h0, 1, 1, 4'h0, 0, 0, 0);
        applyStimulus("t1_r2", 0, 0, 4'h0, 4'h0, 1, 1, 4'h0, 1, 0, 0);
        applyStimulus("t1_f0", 0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 0);
        applyStimulus("t1_e0", 0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 1, 0, 0);
        applyStimulus("t1_f1", 0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 0);
        applyStimulus("t1_e1", 0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 1, 0, 0);

        // PUSH 5 at the last reset cycle.
        doReset("t2");
        applyStimulus("t2_r1", 0, 0, 4'h0, 4'h0, 1, 1, 4'h0, 0, 0, 0);
        applyStimulus("t2_r2", 0, 1, 4'h1, 4'h5, 1, 1, 4'h0, 1, 0, 0);
        applyStimulus("t2_f",  0, 0, 4'h0, 4'h0, 1, 0, 4'h1, 0, 1, 0);
        applyStimulus("t2_e1", 0, 0, 4'h0, 4'h0, 1, 0, 4'h5, 0, 1, 0);
        applyStimulus("t2_e0", 0, 0, 4'h0, 4'h0, 1, 0, 4'h5, 1, 1, 0);
        applyStimulus("t2_ff", 0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 1);
        applyStimulus("t2_fe", 0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 1, 0, 0);

        // Back-to-back stream: PUSH 3, PUSH 4, MUL, OUTL, POP, OUTL.
        doReset("t3");
        applyStimulus("t3_r1",  0, 1, 4'h1, 4'h3, 1, 1, 4'h0, 0, 0, 0);
        applyStimulus("t3_r2",  0, 1, 4'h1, 4'h3, 1, 1, 4'h0, 1, 0, 0);
        applyStimulus("t3_p3f", 0, 1, 4'h1, 4'h4, 1, 0, 4'h1, 0, 1, 0);
        applyStimulus("t3_p3a", 0, 1, 4'h1, 4'h4, 1, 0, 4'h3, 0, 1, 0);
        applyStimulus("t3_p3b", 0, 1, 4'h1, 4'h4, 1, 0, 4'h3, 1, 1, 0);
        applyStimulus("t3_p4f", 0, 1, 4'h9, 4'h0, 1, 0, 4'h1, 0, 1, 1);
        applyStimulus("t3_p4a", 0, 1, 4'h9, 4'h0, 1, 0, 4'h4, 0, 1, 0);
        applyStimulus("t3_p4b", 0, 1, 4'h9, 4'h0, 1, 0, 4'h4, 1, 1, 0);
        applyStimulus("t3_mf",  0, 1, 4'h3, 4'h0, 1, 0, 4'h9, 0, 1, 1);
        applyStimulus("t3_ma",  0, 1, 4'h3, 4'h0, 1, 0, 4'h0, 0, 1, 0);
        applyStimulus("t3_mb",  0, 1, 4'h3, 4'h0, 1, 0, 4'h0, 0, 1, 0);
        applyStimulus("t3_mc",  0, 1, 4'h3, 4'h0, 1, 0, 4'h0, 1, 1, 0);
        applyStimulus("t3_o1f", 0, 1, 4'h2, 4'h0, 1, 0, 4'h3, 0, 1, 1);
        applyStimulus("t3_o1a", 0, 1, 4'h2, 4'h0, 1, 0, 4'h0, 1, 1, 0);
        applyStimulus("t3_ppf", 0, 1, 4'h3, 4'h0, 1, 0, 4'h2, 0, 1, 1);
        applyStimulus("t3_ppa", 0, 1, 4'h3, 4'h0, 1, 0, 4'h0, 0, 1, 0);
        applyStimulus("t3_ppb", 0, 1, 4'h3, 4'h0, 1, 0, 4'h0, 1, 1, 0);
        applyStimulus("t3_o2f", 0, 0, 4'h0, 4'h0, 1, 0, 4'h3, 0, 1, 1);
        applyStimulus("t3_o2a", 0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 1, 1, 0);
        applyStimulus("t3_ff",  0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 1);
        applyStimulus("t3_fe",  0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 1, 0, 0);

        // Valid raised mid-EXEC must wait for the load point.
        doReset("t4");
        applyStimulus("t4_r1", 0, 0, 4'h0, 4'h0, 1, 1, 4'h0, 0, 0, 0);
        applyStimulus("t4_r2", 0, 1, 4'h6, 4'h2, 1, 1, 4'h0, 1, 0, 0);
        applyStimulus("t4_pf", 0, 1, 4'h8, 4'h1, 1, 0, 4'h6, 0, 1, 0);
        applyStimulus("t4_pa", 0, 1, 4'h8, 4'h1, 1, 0, 4'h2, 0, 1, 0);
        applyStimulus("t4_pb", 0, 1, 4'h8, 4'h1, 1, 0, 4'h2, 1, 1, 0);
        applyStimulus("t4_bf", 0, 0, 4'h0, 4'h0, 1, 0, 4'h8, 0, 1, 1);
        applyStimulus("t4_ba", 0, 0, 4'h0, 4'h0, 1, 0, 4'h1, 0, 1, 0);
        applyStimulus("t4_bb", 0, 0, 4'h0, 4'h0, 1, 0, 4'h1, 1, 1, 0);
        applyStimulus("t4_ff", 0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 1);
        applyStimulus("t4_fe", 0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 1, 0, 0);

        // Reset pulsed in the second EXEC cycle of MUL drops it without a retire.
        doReset("t5");
        applyStimulus("t5_r1", 0, 0, 4'h0, 4'h0, 1, 1, 4'h0, 0, 0, 0);
        applyStimulus("t5_r2", 0, 1, 4'h9, 4'h0, 1, 1, 4'h0, 1, 0, 0);
        applyStimulus("t5_mf", 0, 0, 4'h0, 4'h0, 1, 0, 4'h9, 0, 1, 0);
        applyStimulus("t5_ma", 0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 1, 0);
        applyStimulus("t5_mb", 1, 1, 4'h1, 4'h7, 1, 0, 4'h0, 0, 1, 0);
        applyStimulus("t5_r1", 0, 0, 4'h0, 4'h0, 1, 1, 4'h0, 0, 0, 0);
        applyStimulus("t5_r2", 0, 0, 4'h0, 4'h0, 1, 1, 4'h0, 1, 0, 0);
        applyStimulus("t5_ff", 0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 0);
        applyStimulus("t5_fe", 0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 1, 0, 0);

        // Reset at a load point blocks acceptance; then unknown opcode 0xB forwarded with L=1.
        applyStimulus("t6_ff",  0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 0);
        applyStimulus("t6_lrs", 1, 1, 4'h1, 4'h7, 1, 0, 4'h0, 0, 0, 0);
        applyStimulus("t6_r1",  0, 0, 4'h0, 4'h0, 1, 1, 4'h0, 0, 0, 0);
        applyStimulus("t6_r2",  0, 1, 4'hB, 4'h7, 1, 1, 4'h0, 1, 0, 0);
        applyStimulus("t6_bf",  0, 0, 4'h0, 4'h0, 1, 0, 4'hB, 0, 1, 0);
        applyStimulus("t6_ba",  0, 0, 4'h0, 4'h0, 1, 0, 4'h7, 1, 1, 0);
        applyStimulus("t6_ff2", 0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 0, 1);
        applyStimulus("t6_fe2", 0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 1, 0, 0);

        checkOutput();
    end

    task automatic checkOutput();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("[TB] FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

endmodule

// File: doc/stack_cpu_sequencer.md
# stack_cpu_sequencer

Host-side driver for the nibble-serial stack calculator core. Accepts whole instructions (opcode plus operand) over a valid/ready command port. Replays them onto the core's 4-bit input bus and reset line, with cycle-exact alignment to the core's fetch/execute timing. When no command is pending, it inserts NOOP filler so the core never fetches garbage. Sits in the same clock domain as the core and is instantiated beside it in test harnesses and the host wrapper.

## Interface
- RST_CYCLES, default 2: cycles `cpu_rst` is held high after `rst`. Legal range 1..15.
- clk  in  1  system clock; also clocks the stack core.
- rst  in  1  synchronous, active-high reset of this block.
- cmd_valid  in  1  host presents an instruction.
- cmd_ready  out  1  instruction accepted on this edge if `cmd_valid` is also high.
- cmd_op  in  4  opcode. 0x1 PUSH, 0x2 POP, 0x3 OUTL, 0x4 OUTH, 0x5 SWAP, 0x6 PUSF, 0x7 REPL, 0x8 BIN, 0x9 MUL; all others are NOOP.
- cmd_arg  in  4  operand nibble: PUSH value, PUSF/REPL/BIN selector. Ignored by other ops.
- cpu_rst  out  1  drives the core's reset input (registered).
- cpu_inbits  out  4  drives the core's 4-bit data/opcode input (registered).
- busy  out  1  high while a host-issued instruction occupies FETCH/EXEC.
- retire  out  1  one-cycle pulse in the first cycle after a host instruction's last EXEC cycle.

## Operation
- States: RESET, FETCH, EXEC. A 4-bit down-counter `cnt` times RESET and EXEC.
- Held registers: `op_q` and `arg_q` (4 bits each) and `user_q` (1 = host command, 0 = filler).
- Exec length L(op):
  - 0x1, 0x2, 0x5, 0x6, 0x7, 0x8: L = 2.
  - 0x9: L = 3.
  - 0x3, 0x4 and every other opcode: L = 1.
- RESET:
  - `cpu_rst` = 1 and `cpu_inbits` = 0.
  - Lasts RST_CYCLES cycles, then goes to FETCH.
- FETCH:
  - Exactly 1 cycle. `cpu_inbits` = `op_q`, `cpu_rst` = 0.
  - Next state is EXEC with `cnt` = L(`op_q`) − 1.
- EXEC:
  - `cpu_inbits` = `arg_q` for every EXEC cycle. For L = 2 ops the core samples the operand in the second EXEC cycle.
  - `cnt` decrements each cycle. When `cnt` = 0, next state is FETCH.
- Load point: the last RESET cycle, or an EXEC cycle with `cnt` = 0.
  - `cmd_ready` is combinational and high only at the load point.
  - If `cmd_valid` is high there: `op_q` ← `cmd_op`, `arg_q` ← `cmd_arg`, `user_q` ← 1.
  - Otherwise: `op_q` ← 0x0, `arg_q` ← 0x0, `user_q` ← 0. The filler NOOP costs 2 cycles.
- busy = `user_q` and (state is FETCH or EXEC).
- retire: registered; set at the edge leaving the last EXEC cycle when `user_q` = 1.
- Unknown opcodes are forwarded unchanged and use L = 1, matching the core's NOOP handling.

## Timing
- Reset values: `cpu_rst` = 1, `cpu_inbits` = 0x0, `cmd_ready` = 0, `busy` = 0, `retire` = 0, state RESET, `cnt` = RST_CYCLES − 1, `op_q`/`arg_q`/`user_q` = 0.
- `rst` asserted in any state (including mid-EXEC):
  - The next edge re-enters RESET and re-asserts `cpu_rst`.
  - The instruction in flight is dropped without a retire.
  - A command presented at that edge is not accepted.
- Slots per instruction, FETCH included: L + 1. So 3 for PUSH-class, 4 for MUL, 2 for OUTL/OUTH/NOOP.
- Back-to-back: with `cmd_valid` held high, throughput is one instruction per L + 1 cycles with no filler slots.
- Accept-to-FETCH latency: 1 cycle (FETCH is the cycle after the accepting edge).
- Host contract: `cmd_op`/`cmd_arg` only need to be stable at the accepting edge. The sequencer keeps no combinational path from cmd inputs to `cpu_*`.
- `cmd_valid` low at a load point is never an error; a filler NOOP is issued and `cmd_ready` re-asserts 2 cycles later.

## Test plan
- Reset, RST_CYCLES=2:
  - `cpu_rst` is 1,1 then 0.
  - `cmd_ready` is high only in the 2nd reset cycle.
  - With no command, `cpu_inbits` = 0 and `cmd_ready` pulses every 2 cycles.
- PUSH 5 accepted at the last reset cycle:
  - `cpu_inbits` = 1,5,5; `busy` is high for those 3 cycles.
  - `retire` pulses in the 4th cycle.
  - Paired with the core, OUTL then mode-0 output shows 0x05.
- Stream PUSH 3, PUSH 4, MUL, OUTL, POP, OUTL with `cmd_valid` held high:
  - `cmd_ready` gaps are 3,3,4,2,3.
  - No 0x0 filler FETCH appears.
  - Core out_dff low nibble reads 0xC, then 0x0.
- `cmd_valid` asserted while `cmd_ready` = 0 (mid-EXEC):
  - Not accepted until the load point.
  - `op_q` is unchanged and no extra retire occurs.
- `rst` pulsed in the 2nd EXEC cycle of MUL:
  - Next cycle `cpu_rst` = 1 and `busy` = 0.
  - No retire; the sequence restarts from RESET.
- Opcode 0xB with arg 0x7: `cpu_inbits` = B,7, L = 1, retire after 2 cycles.
